// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the program counter and decode.
// Issues imem requests at the current PC, advances the counter on each accepted
// request, pairs in-order responses with their requesting PC in a small circular
// queue, and hands entries to decode over valid/ready. A flush discards all
// wrong-path entries and remembers how many in-flight responses must be dropped.
module fetch_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic                   pc_advance,
    input  logic                   flush,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0]  id_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Entry payload; validity lives in the separate filled vector.
    logic [ADDR_WIDTH-1:0]  pc_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]       filled;

    // head: next entry for decode; tail: next free entry;
    // fill_ptr: oldest entry still waiting for its response.
    ptr_t head;
    ptr_t tail;
    ptr_t fill_ptr;

    // count: allocated entries; pend_cnt: allocated but unfilled;
    // drop_cnt: wrong-path responses still to be discarded.
    cnt_t count;
    cnt_t pend_cnt;
    cnt_t drop_cnt;

    logic           fire;
    logic           pop;
    logic           resp_drop;
    logic           resp_fill;
    logic [CNT_W:0] occupancy;

    // Handshake decode: request gating, pop, and response steering.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        occupancy      = {1'b0, count} + {1'b0, drop_cnt};
        imem_req_valid = reset & ~flush & (occupancy < (CNT_W+1)'(DEPTH));
        fire           = imem_req_valid & imem_req_ready;
        pc_advance     = fire;
        imem_req_addr  = pc;
        id_valid       = reset & filled[head] & ~flush;
        pop            = id_valid & id_ready;
        id_instr       = instr_q[head];
        id_pc          = pc_q[head];
        resp_drop      = imem_resp_valid & (drop_cnt != '0);
        resp_fill      = imem_resp_valid & (drop_cnt == '0) & (pend_cnt != '0);
    end

    // Queue bookkeeping: pointers, counts, filled bits and the drop counter.
    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            filled   <= '0;
        end else if (flush) begin
            // Every unfilled entry still has a response coming; the one arriving now is
            // already being discarded, so it leaves the outstanding total.
            head     <= tail;
            fill_ptr <= tail;
            count    <= '0;
            pend_cnt <= '0;
            filled   <= '0;
            drop_cnt <= drop_cnt + pend_cnt - cnt_t'(imem_resp_valid);
        end else begin
            if (fire) begin
                tail <= tail + ptr_t'(1);
            end
            if (resp_fill) begin
                filled[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + ptr_t'(1);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - cnt_t'(1);
            end
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + ptr_t'(1);
            end
            count    <= count + cnt_t'(fire) - cnt_t'(pop);
            pend_cnt <= pend_cnt + cnt_t'(fire) - cnt_t'(resp_fill);
        end
    end

    // Payload capture: PC at allocation, instruction when its response lands.
    // NOTE: payload storage is deliberately not reset; the filled bits gate everything visible.
    always_ff @(posedge clk) begin
        if (fire) begin
            pc_q[tail] <= pc;
        end
        if (resp_fill && !flush) begin
            instr_q[fill_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed, table-driven bench for fetch_queue. The bench models
// the program counter (advance on pc_advance, load on flush) and an in-order
// fixed-latency instruction memory returning addr ^ 0xA5A5A5A5.
module tb_fetch_queue;

    localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;
    localparam logic [31:0] DC    = 32'hxxxx_xxxx;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_queue #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .DEPTH       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_advance      (pc_advance),
        .flush           (flush),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          sect;
        logic        id_ready;
        logic        req_ready;
        logic        flush;
        logic [31:0] flush_pc;
        logic        exp_rv;
        logic        exp_adv;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    mreq_t       mq[$];
    vec_t        vecs[$];
    int          lat;
    int          cyc;
    logic [31:0] flush_pc;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s, input logic ir, input logic rr, input logic fl,
                                input logic [31:0] fpc, input logic rv, input logic adv,
                                input logic iv, input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.sect      = s;
        v.id_ready  = ir;
        v.req_ready = rr;
        v.flush     = fl;
        v.flush_pc  = fpc;
        v.exp_rv    = rv;
        v.exp_adv   = adv;
        v.exp_iv    = iv;
        v.exp_pc    = epc;
        v.exp_addr  = eaddr;
        return v;
    endfunction

    // Called at a negedge: sample the handshake, cross the edge, update the
    // counter and memory models and present this cycle's memory response.
    task automatic advance();
        logic        f;
        logic [31:0] a;
        mreq_t       r;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        @(posedge clk);
        #1;
        if (flush) pc = flush_pc;
        else if (f) pc = pc + 32'd4;
        if (f) begin
            r.addr = a;
            r.due  = cyc + lat;
            mq.push_back(r);
        end
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr ^ MAGIC;
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset(input int lat_i);
        reset           = 1'b0;
        flush           = 1'b0;
        id_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pc              = '0;
        flush_pc        = '0;
        mq.delete();
        lat = lat_i;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string tag;
        id_ready       = v.id_ready;
        imem_req_ready = v.req_ready;
        flush          = v.flush;
        flush_pc       = v.flush_pc;
        @(negedge clk);
        tag = $sformatf("s%0d.k%0d", v.sect, k);
        check({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.exp_rv});
        check({tag, " pc_advance"}, {31'b0, pc_advance}, {31'b0, v.exp_adv});
        check({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, v.exp_iv});
        check({tag, " req_addr=pc"}, imem_req_addr, pc);
        if (!$isunknown(v.exp_addr)) check({tag, " req_addr"}, imem_req_addr, v.exp_addr);
        if (v.exp_iv) begin
            check({tag, " id_pc"}, id_pc, v.exp_pc);
            check({tag, " id_instr"}, id_instr, v.exp_pc ^ MAGIC);
        end
        advance();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int sec_lat[5];
        int k;
        sec_lat = '{1, 1, 3, 2, 1};

        // Section 0: streaming, 1-cycle memory, decode always ready.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, (i >= 2), (i >= 2) ? 32'(4 * (i - 2)) : DC, 32'(4 * i)));

        // Section 1: decode stalled until the queue is full, then released.
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, DC,       32'h00));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, DC,       32'h04));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 1, 32'h00,   32'h08));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 1, 32'h00,   32'h0C));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 32'h00,   32'h10));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 32'h00,   32'h10));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 32'h04,   32'h10));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 32'h08,   32'h14));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 32'h0C,   32'h18));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 32'h10,   32'h1C));

        // Section 2: 3-cycle memory, flush to 0x100 with three requests in flight.
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h000));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h004));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h008));
        vecs.push_back(mk(2, 1, 1, 1, 32'h100, 0, 0, 0, DC,    32'h00C));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h100));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h104));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h108));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 0, DC,     32'h10C));
        vecs.push_back(mk(2, 1, 1, 0, 0,      0, 0, 1, 32'h100, 32'h110));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 1, 32'h104, 32'h110));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 1, 32'h108, 32'h114));
        vecs.push_back(mk(2, 1, 1, 0, 0,      1, 1, 1, 32'h10C, 32'h118));

        // Section 3: 2-cycle memory, flush coincident with a response, filled head masked.
        vecs.push_back(mk(3, 0, 1, 0, 0,      1, 1, 0, DC,     32'h000));
        vecs.push_back(mk(3, 0, 1, 0, 0,      1, 1, 0, DC,     32'h004));
        vecs.push_back(mk(3, 0, 1, 0, 0,      1, 1, 0, DC,     32'h008));
        vecs.push_back(mk(3, 0, 1, 1, 32'h200, 0, 0, 0, DC,    32'h00C));
        vecs.push_back(mk(3, 1, 1, 0, 0,      1, 1, 0, DC,     32'h200));
        vecs.push_back(mk(3, 1, 1, 0, 0,      1, 1, 0, DC,     32'h204));
        vecs.push_back(mk(3, 1, 1, 0, 0,      1, 1, 0, DC,     32'h208));
        vecs.push_back(mk(3, 1, 1, 0, 0,      1, 1, 1, 32'h200, 32'h20C));
        vecs.push_back(mk(3, 1, 1, 0, 0,      1, 1, 1, 32'h204, 32'h210));

        // Section 4: memory back-pressure for 5 cycles with decode stalled.
        vecs.push_back(mk(4, 0, 1, 0, 0, 1, 1, 0, DC, 32'h00));
        vecs.push_back(mk(4, 0, 1, 0, 0, 1, 1, 0, DC, 32'h04));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(4, 0, 0, 0, 0, 1, 0, 1, 32'h00, 32'h08));
        vecs.push_back(mk(4, 1, 1, 0, 0, 1, 1, 1, 32'h00, 32'h08));
        vecs.push_back(mk(4, 1, 1, 0, 0, 1, 1, 1, 32'h04, 32'h0C));
        vecs.push_back(mk(4, 1, 1, 0, 0, 1, 1, 1, 32'h08, 32'h10));

        for (int s = 0; s < 5; s++) begin
            do_reset(sec_lat[s]);
            k = 0;
            foreach (vecs[i]) begin
                if (vecs[i].sect == s) begin
                    run_vec(vecs[i], k);
                    k++;
                end
            end
        end

        // Reset asserted between edges with two filled entries.
        do_reset(1);
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            advance();
        end
        #1;
        check("rst.pre id_valid", {31'b0, id_valid}, 32'd1);
        check("rst.pre id_pc", id_pc, 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("rst.async id_valid", {31'b0, id_valid}, 32'd0);
        check("rst.async req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst.async pc_advance", {31'b0, pc_advance}, 32'd0);
        mq.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pc              = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
        @(negedge clk);
        check("rst.k0 id_valid", {31'b0, id_valid}, 32'd0);
        check("rst.k0 pc_advance", {31'b0, pc_advance}, 32'd1);
        check("rst.k0 req_addr", imem_req_addr, 32'h0);
        advance();
        @(negedge clk);
        check("rst.k1 id_valid", {31'b0, id_valid}, 32'd0);
        check("rst.k1 req_addr", imem_req_addr, 32'h4);
        advance();
        @(negedge clk);
        check("rst.k2 id_valid", {31'b0, id_valid}, 32'd1);
        check("rst.k2 id_pc", id_pc, 32'h0);
        check("rst.k2 id_instr", id_instr, MAGIC);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
